// File: rtl/alu_pkg.sv
// Shared opcode constants, FSM state encoding and opcode classification
// for the multicycle ALU.
package alu_pkg;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_SLTU = 4'b0101;
  localparam logic [3:0] OP_SLT  = 4'b0110;
  localparam logic [3:0] OP_SLL  = 4'b0111;
  localparam logic [3:0] OP_SRL  = 4'b1000;
  localparam logic [3:0] OP_SRA  = 4'b1001;
  localparam logic [3:0] OP_MUL  = 4'b1010;
  localparam logic [3:0] OP_DIVU = 4'b1011;
  localparam logic [3:0] OP_REMU = 4'b1100;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } alu_state_e;

  // Opcodes served by the bit-serial mul/div datapath.
  function automatic logic is_iter_op(input logic [3:0] op);
    return (op == OP_MUL) || (op == OP_DIVU) || (op == OP_REMU);
  endfunction

endpackage

// File: rtl/alu_iter_muldiv.sv
// Bit-serial datapath: shift-add multiply and restoring divide, one bit per
// cycle for WIDTH cycles after a start strobe.
module alu_iter_muldiv
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             done,
  output logic [WIDTH-1:0] prod,
  output logic [WIDTH-1:0] quot,
  output logic [WIDTH-1:0] rem
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  logic [CNT_W-1:0] cnt_q;
  logic             busy_q;
  logic [WIDTH-1:0] acc_q, mcand_q, mplier_q;
  logic [WIDTH-1:0] quo_q, dvsr_q;
  logic [WIDTH:0]   rem_q;

  logic [WIDTH-1:0] acc_nxt, quo_nxt;
  logic [WIDTH:0]   rem_nxt, shifted, diff;
  logic             last;

  // One step of each algorithm; results are exposed so the top can capture
  // the final value on the same edge the last step retires.
  always_comb begin
    acc_nxt = acc_q;
    if (mplier_q[0]) acc_nxt = acc_q + mcand_q;
    shifted = {rem_q[WIDTH-1:0], quo_q[WIDTH-1]};
    diff    = shifted - {1'b0, dvsr_q};
    if (diff[WIDTH]) begin
      rem_nxt = shifted;
      quo_nxt = {quo_q[WIDTH-2:0], 1'b0};
    end else begin
      rem_nxt = diff;
      quo_nxt = {quo_q[WIDTH-2:0], 1'b1};
    end
  end

  assign last = busy_q && (cnt_q == CNT_W'(WIDTH - 1));
  assign done = last;
  assign prod = acc_nxt;
  assign quot = quo_nxt;
  assign rem  = rem_nxt[WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      quo_q    <= '0;
      dvsr_q   <= '0;
      rem_q    <= '0;
    end else if (start) begin
      cnt_q    <= '0;
      busy_q   <= 1'b1;
      acc_q    <= '0;
      mcand_q  <= op_a;
      mplier_q <= op_b;
      quo_q    <= op_a;
      dvsr_q   <= op_b;
      rem_q    <= '0;
    end else if (busy_q) begin
      cnt_q    <= cnt_q + 1'b1;
      busy_q   <= ~last;
      acc_q    <= acc_nxt;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      quo_q    <= quo_nxt;
      rem_q    <= rem_nxt;
    end
  end

endmodule

// File: rtl/alu_multicycle.sv
// Multicycle ALU with valid/ready handshake: single-cycle ops finish in one
// cycle, mul/divu/remu run on the bit-serial datapath for WIDTH cycles.
module alu_multicycle
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_op_a,
  input  logic [WIDTH-1:0] i_op_b,
  input  logic [3:0]       i_alu_op,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_alu_out,
  output logic             o_zero,
  output logic             o_err
);

  localparam int SH_W = $clog2(WIDTH);

  // Returns {err, result} for everything resolved in the accept cycle,
  // including the divide-by-zero and illegal-opcode outcomes.
  function automatic logic [WIDTH:0] single_op(input logic [3:0]       op,
                                               input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
    logic signed [WIDTH-1:0] sa, sb;
    logic [SH_W-1:0]         sh;
    logic [WIDTH-1:0]        r;
    logic                    e;
    sa = a;
    sb = b;
    sh = b[SH_W-1:0];
    r  = '0;
    e  = 1'b0;
    case (op)
      OP_ADD:  r = a + b;
      OP_SUB:  r = a - b;
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      OP_SLTU: r = {{(WIDTH-1){1'b0}}, (a < b)};
      OP_SLT:  r = {{(WIDTH-1){1'b0}}, (sa < sb)};
      OP_SLL:  r = a << sh;
      OP_SRL:  r = a >> sh;
      OP_SRA:  r = sa >>> sh;
      OP_DIVU: begin r = '1; e = 1'b1; end
      OP_REMU: begin r = a;  e = 1'b1; end
      default: e = 1'b1;
    endcase
    return {e, r};
  endfunction

  alu_state_e       state_q, state_nxt;
  logic [3:0]       op_q;
  logic [WIDTH-1:0] res_q;
  logic             zero_q, err_q;

  logic             accept, iter_start, iter_done;
  logic [WIDTH:0]   single_res;
  logic [WIDTH-1:0] iter_prod, iter_quot, iter_rem, iter_res;

  assign accept     = i_valid && (state_q == ST_IDLE);
  assign iter_start = accept && is_iter_op(i_alu_op) &&
                      ((i_alu_op == OP_MUL) || (i_op_b != '0));
  assign single_res = single_op(i_alu_op, i_op_a, i_op_b);

  alu_iter_muldiv #(.WIDTH(WIDTH)) u_iter (
    .clk   (i_clk),
    .rst   (i_rst),
    .start (iter_start),
    .op_a  (i_op_a),
    .op_b  (i_op_b),
    .done  (iter_done),
    .prod  (iter_prod),
    .quot  (iter_quot),
    .rem   (iter_rem)
  );

  always_comb begin
    iter_res = iter_rem;
    if (op_q == OP_MUL)       iter_res = iter_prod;
    else if (op_q == OP_DIVU) iter_res = iter_quot;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) state_q <= ST_IDLE;
    else       state_q <= state_nxt;
  end

  always_comb begin
    state_nxt = state_q;
    o_ready   = 1'b0;
    o_valid   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        o_ready = 1'b1;
        if (i_valid) state_nxt = iter_start ? ST_BUSY : ST_DONE;
      end
      ST_BUSY: if (iter_done) state_nxt = ST_DONE;
      ST_DONE: begin
        o_valid = 1'b1;
        if (i_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Result registers change only on accept or on the final iteration, so
  // they stay frozen throughout DONE.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      op_q   <= '0;
      res_q  <= '0;
      zero_q <= 1'b0;
      err_q  <= 1'b0;
    end else if (accept) begin
      op_q <= i_alu_op;
      if (!iter_start) begin
        res_q  <= single_res[WIDTH-1:0];
        zero_q <= (single_res[WIDTH-1:0] == '0);
        err_q  <= single_res[WIDTH];
      end
    end else if (iter_done && (state_q == ST_BUSY)) begin
      res_q  <= iter_res;
      zero_q <= (iter_res == '0);
      err_q  <= 1'b0;
    end
  end

  assign o_alu_out = res_q;
  assign o_zero    = zero_q;
  assign o_err     = err_q;

endmodule

// File: tb/tb_alu_multicycle.sv
// Scoreboard bench for alu_multicycle: directed corner cases plus random ops
// checked against a plain-arithmetic reference model.
module tb_alu_multicycle;

  localparam int W  = 32;
  localparam int SH = $clog2(W);

  localparam logic [3:0] ADD = 4'd0, SUB = 4'd1, AND_ = 4'd2, OR_ = 4'd3;
  localparam logic [3:0] XOR_ = 4'd4, SLTU = 4'd5, SLT = 4'd6, SLL = 4'd7;
  localparam logic [3:0] SRL = 4'd8, SRA = 4'd9, MUL = 4'd10, DIVU = 4'd11;
  localparam logic [3:0] REMU = 4'd12;

  logic         clk = 1'b0;
  logic         rst;
  logic         req_valid;
  logic         dut_ready;
  logic [W-1:0] op_a, op_b;
  logic [3:0]   alu_op;
  logic         res_valid;
  logic         cons_ready;
  logic [W-1:0] alu_out;
  logic         zero, err;

  logic hold, force_rdy, rand_rdy;
  assign cons_ready = hold ? force_rdy : rand_rdy;

  int     checks = 0;
  int     errors = 0;
  longint cyc = 0;

  typedef struct {
    logic [W-1:0] res;
    logic         err;
    int           lat;
    longint       acc_cyc;
  } exp_t;
  exp_t exp_q[$];

  alu_multicycle #(.WIDTH(W)) dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_valid   (req_valid),
    .o_ready   (dut_ready),
    .i_op_a    (op_a),
    .i_op_b    (op_b),
    .i_alu_op  (alu_op),
    .o_valid   (res_valid),
    .i_ready   (cons_ready),
    .o_alu_out (alu_out),
    .o_zero    (zero),
    .o_err     (err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: bound expired at cycle %0d", name, cyc);
  endtask

  // Reference model straight from the opcode table.
  function automatic void model(input logic [3:0] op, input logic [W-1:0] a,
                                input logic [W-1:0] b, output logic [W-1:0] r,
                                output logic e, output int lat);
    logic [2*W-1:0] p;
    logic [SH-1:0]  s;
    s   = b[SH-1:0];
    e   = 1'b0;
    lat = 1;
    r   = '0;
    case (op)
      ADD:  r = a + b;
      SUB:  r = a - b;
      AND_: r = a & b;
      OR_:  r = a | b;
      XOR_: r = a ^ b;
      SLTU: r = (a < b) ? W'(1) : W'(0);
      SLT:  r = ($signed(a) < $signed(b)) ? W'(1) : W'(0);
      SLL:  r = a << s;
      SRL:  r = a >> s;
      SRA:  r = W'($signed(a) >>> s);
      MUL: begin
        p   = {{W{1'b0}}, a} * {{W{1'b0}}, b};
        r   = p[W-1:0];
        lat = W + 1;
      end
      DIVU: if (b == '0) begin r = '1; e = 1'b1; end
            else begin r = a / b; lat = W + 1; end
      REMU: if (b == '0) begin r = a; e = 1'b1; end
            else begin r = a % b; lat = W + 1; end
      default: begin r = '0; e = 1'b1; end
    endcase
  endfunction

  task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    int   n;
    n = 0;
    @(negedge clk);
    while (!dut_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!dut_ready) begin
      timeout("issue_wait_ready");
      return;
    end
    req_valid = 1'b1;
    alu_op    = op;
    op_a      = a;
    op_b      = b;
    model(op, a, b, e.res, e.err, e.lat);
    e.acc_cyc = cyc + 1;
    exp_q.push_back(e);
    @(negedge clk);
    req_valid = 1'b0;
    alu_op    = 4'($urandom);
    op_a      = $urandom;
    op_b      = $urandom;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || !dut_ready) && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (n >= 400) timeout("drain");
  endtask

  initial begin
    rand_rdy = 1'b1;
    forever begin
      @(negedge clk);
      rand_rdy = ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor: pops on each new result, then enforces stability while held.
  initial begin
    exp_t         e;
    logic         prev_valid;
    logic [W-1:0] h_out;
    logic         h_zero, h_err;
    prev_valid = 1'b0;
    h_out = '0;
    h_zero = 1'b0;
    h_err = 1'b0;
    forever begin
      @(negedge clk);
      if (res_valid && !prev_valid) begin
        if (exp_q.size() == 0) begin
          timeout("unexpected_result");
        end else begin
          e = exp_q.pop_front();
          check("result", alu_out, e.res);
          check("err_flag", err, e.err);
          check("zero_flag", zero, (e.res == '0));
          check("latency", 64'(cyc - e.acc_cyc + 1), 64'(e.lat));
        end
        h_out  = alu_out;
        h_zero = zero;
        h_err  = err;
      end else if (res_valid) begin
        check("held_result", {alu_out, zero, err}, {h_out, h_zero, h_err});
      end
      if (res_valid) check("ready_low_in_done", dut_ready, 1'b0);
      prev_valid = res_valid;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, viol, seen;
    logic [W-1:0] a, b;
    rst = 1'b1;
    req_valid = 1'b0;
    alu_op = '0;
    op_a = '0;
    op_b = '0;
    hold = 1'b1;
    force_rdy = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready", dut_ready, 1'b1);
    check("rst_valid", res_valid, 1'b0);
    check("rst_out", {alu_out, zero, err}, '0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_idle", {dut_ready, res_valid, alu_out, zero, err}, {1'b1, 1'b0, {W{1'b0}}, 2'b00});

    // Wraparound, compare ops
    issue(ADD, 32'hFFFF_FFFF, 32'h1);
    issue(SLT, 32'hFFFF_FFFF, 32'h1);
    issue(SLTU, 32'hFFFF_FFFF, 32'h1);

    // Multiply: o_ready must stay low until the result appears
    issue(MUL, 32'h0001_0003, 32'h0000_0005);
    n = 0;
    viol = 0;
    while (!res_valid && n < 100) begin
      if (dut_ready) viol++;
      @(negedge clk);
      n++;
    end
    if (!res_valid) timeout("mul_result");
    check("mul_ready_low_busy", viol, 0);

    issue(DIVU, 32'd100, 32'd7);
    issue(REMU, 32'd100, 32'd7);
    issue(DIVU, 32'd5, 32'd0);
    issue(REMU, 32'd9, 32'd0);
    issue(4'd13, 32'd1, 32'd2);
    drain();

    // Consumer stalls for 5 cycles in DONE
    force_rdy = 1'b0;
    issue(ADD, 32'd3, 32'd4);
    n = 0;
    while (!res_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!res_valid) timeout("hold_result");
    repeat (5) begin
      @(negedge clk);
      check("hold_valid", res_valid, 1'b1);
      check("hold_ready", dut_ready, 1'b0);
    end
    force_rdy = 1'b1;
    @(negedge clk);
    check("release_ready", dut_ready, 1'b1);
    check("release_valid", res_valid, 1'b0);
    drain();

    // Reset during cycle 10 of a divide aborts it
    issue(DIVU, 32'd100, 32'd7);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_ready", dut_ready, 1'b1);
    check("abort_valid", res_valid, 1'b0);
    check("abort_out", {alu_out, zero, err}, '0);
    exp_q.delete();
    rst = 1'b0;
    seen = 0;
    repeat (60) begin
      @(negedge clk);
      if (res_valid) seen++;
    end
    check("abort_no_result", seen, 0);

    // Random traffic with a randomly stalling consumer
    hold = 1'b0;
    for (int i = 0; i < 80; i++) begin
      a = $urandom;
      case ($urandom_range(0, 3))
        0:       b = '0;
        1:       b = W'($urandom_range(1, 40));
        default: b = $urandom;
      endcase
      if ($urandom_range(0, 7) == 0) a = '0;
      issue(4'($urandom_range(0, 15)), a, b);
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
